sram_axil: RTL and testbench

Parametrised AXI4-Lite slave SRAM, the next generation of the peripheral on-chip RAM. It generalises data width and depth, and decouples the AW and W channels through one-entry holding registers. It adds a B (write response) channel, error responses for out-of-range addresses, and round-robin read/write arbitration. It sits on the peripheral AXI4-Lite interconnect as a single-clock synchronous memory target.

---
 rtl/sram_axil.sv | 211 +++++++++++++++++++++
 tb/tb_sram_axil.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_axil.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | sram_axil : AXI4-Lite slave SRAM, decoupled AW/W/AR holding registers,   |
// |             B channel, SLVERR on out-of-range, round-robin R/W arbiter.  |
// | Revision  : 1.0                                                          |
// +--------------------------------------------------------------------------+
module sram_axil #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 4096
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   sram_axi_awaddr,
  input  logic                    sram_axi_awvalid,
  output logic                    sram_axi_awready,
  input  logic [DATA_WIDTH-1:0]   sram_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] sram_axi_wstrb,
  input  logic                    sram_axi_wvalid,
  output logic                    sram_axi_wready,
  output logic [1:0]              sram_axi_bresp,
  output logic                    sram_axi_bvalid,
  input  logic                    sram_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   sram_axi_araddr,
  input  logic                    sram_axi_arvalid,
  output logic                    sram_axi_arready,
  output logic [DATA_WIDTH-1:0]   sram_axi_rdata,
  output logic [1:0]              sram_axi_rresp,
  output logic                    sram_axi_rvalid,
  input  logic                    sram_axi_rready
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int LSB   = $clog2(NB);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int HI_W  = ADDR_WIDTH - LSB - IDX_W;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    LAST_WR = 1'b0,
    LAST_RD = 1'b1
  } last_e;

  logic                  aw_full_q, aw_full_d;
  logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic                  w_full_q,  w_full_d;
  logic [DATA_WIDTH-1:0] w_data_q,  w_data_d;
  logic [NB-1:0]         w_strb_q,  w_strb_d;
  logic                  ar_full_q, ar_full_d;
  logic [ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
  logic                  bvalid_q,  bvalid_d;
  logic [1:0]            bresp_q,   bresp_d;
  logic                  rvalid_q,  rvalid_d;
  logic [1:0]            rresp_q,   rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q,   rdata_d;
  last_e                 last_q,    last_d;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  w_aw_in_range;
  logic                  w_ar_in_range;
  logic [IDX_W-1:0]      w_aw_idx;
  logic [IDX_W-1:0]      w_ar_idx;
  logic                  w_wr_elig;
  logic                  w_rd_elig;
  logic                  w_wr_grant;
  logic                  w_rd_grant;
  logic [DATA_WIDTH-1:0] w_merged;
  logic                  w_addr_unused;

  // Readiness depends on holding state only, never on the valid inputs.
  assign sram_axi_awready = ~aw_full_q & ~rst;
  assign sram_axi_wready  = ~w_full_q  & ~rst;
  assign sram_axi_arready = ~ar_full_q & ~rst;

  assign sram_axi_bvalid = bvalid_q;
  assign sram_axi_bresp  = bresp_q;
  assign sram_axi_rvalid = rvalid_q;
  assign sram_axi_rresp  = rresp_q;
  assign sram_axi_rdata  = rdata_q;

  assign w_aw_idx      = aw_addr_q[LSB +: IDX_W];
  assign w_ar_idx      = ar_addr_q[LSB +: IDX_W];
  assign w_addr_unused = ^{aw_addr_q, ar_addr_q};

  generate
    if (HI_W > 0) begin : g_range_chk
      assign w_aw_in_range = (aw_addr_q[ADDR_WIDTH-1 -: HI_W] == '0);
      assign w_ar_in_range = (ar_addr_q[ADDR_WIDTH-1 -: HI_W] == '0);
    end else begin : g_range_all
      assign w_aw_in_range = 1'b1;
      assign w_ar_in_range = 1'b1;
    end
  endgenerate

  assign w_wr_elig = aw_full_q & w_full_q & (~bvalid_q | sram_axi_bready);
  assign w_rd_elig = ar_full_q & (~rvalid_q | sram_axi_rready);

  // On a tie the direction not granted last wins.
  assign w_wr_grant = w_wr_elig & (~w_rd_elig | (last_q == LAST_RD));
  assign w_rd_grant = w_rd_elig & (~w_wr_elig | (last_q == LAST_WR));

  always_comb begin
    w_merged = mem_q[w_aw_idx];
    for (int i = 0; i < NB; i++) begin
      if (w_strb_q[i]) begin
        w_merged[i*8 +: 8] = w_data_q[i*8 +: 8];
      end
    end
  end

  always_comb begin
    aw_full_d = aw_full_q;
    aw_addr_d = aw_addr_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    ar_full_d = ar_full_q;
    ar_addr_d = ar_addr_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    last_d    = last_q;

    if (sram_axi_awvalid && sram_axi_awready) begin
      aw_full_d = 1'b1;
      aw_addr_d = sram_axi_awaddr;
    end else if (w_wr_grant) begin
      aw_full_d = 1'b0;
    end

    if (sram_axi_wvalid && sram_axi_wready) begin
      w_full_d = 1'b1;
      w_data_d = sram_axi_wdata;
      w_strb_d = sram_axi_wstrb;
    end else if (w_wr_grant) begin
      w_full_d = 1'b0;
    end

    if (sram_axi_arvalid && sram_axi_arready) begin
      ar_full_d = 1'b1;
      ar_addr_d = sram_axi_araddr;
    end else if (w_rd_grant) begin
      ar_full_d = 1'b0;
    end

    if (w_wr_grant) begin
      bvalid_d = 1'b1;
      bresp_d  = w_aw_in_range ? RESP_OKAY : RESP_SLVERR;
      last_d   = LAST_WR;
    end else if (sram_axi_bready) begin
      bvalid_d = 1'b0;
    end

    // rdata only changes on issue, so it holds while the master stalls.
    if (w_rd_grant) begin
      rvalid_d = 1'b1;
      rresp_d  = w_ar_in_range ? RESP_OKAY : RESP_SLVERR;
      rdata_d  = w_ar_in_range ? mem_q[w_ar_idx] : '0;
      last_d   = LAST_RD;
    end else if (sram_axi_rready) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_full_q <= 1'b0;
      aw_addr_q <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      ar_full_q <= 1'b0;
      ar_addr_q <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
      last_q    <= LAST_RD;
    end else begin
      aw_full_q <= aw_full_d;
      aw_addr_q <= aw_addr_d;
      w_full_q  <= w_full_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      ar_full_q <= ar_full_d;
      ar_addr_q <= ar_addr_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      last_q    <= last_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_wr_grant && w_aw_in_range) begin
      mem_q[w_aw_idx] <= w_merged;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_axil.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sram_axil : scoreboard bench for sram_axil (32-bit data, 4096 words).  |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
module tb_sram_axil;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] sram_axi_awaddr = '0;
  logic        sram_axi_awvalid = 1'b0;
  logic        sram_axi_awready;
  logic [31:0] sram_axi_wdata = '0;
  logic [3:0]  sram_axi_wstrb = '0;
  logic        sram_axi_wvalid = 1'b0;
  logic        sram_axi_wready;
  logic [1:0]  sram_axi_bresp;
  logic        sram_axi_bvalid;
  logic        sram_axi_bready = 1'b1;
  logic [31:0] sram_axi_araddr = '0;
  logic        sram_axi_arvalid = 1'b0;
  logic        sram_axi_arready;
  logic [31:0] sram_axi_rdata;
  logic [1:0]  sram_axi_rresp;
  logic        sram_axi_rvalid;
  logic        sram_axi_rready = 1'b1;

  sram_axil #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .DEPTH     (4096)
  ) u_dut (
    .clk             (clk),
    .rst             (rst),
    .sram_axi_awaddr (sram_axi_awaddr),
    .sram_axi_awvalid(sram_axi_awvalid),
    .sram_axi_awready(sram_axi_awready),
    .sram_axi_wdata  (sram_axi_wdata),
    .sram_axi_wstrb  (sram_axi_wstrb),
    .sram_axi_wvalid (sram_axi_wvalid),
    .sram_axi_wready (sram_axi_wready),
    .sram_axi_bresp  (sram_axi_bresp),
    .sram_axi_bvalid (sram_axi_bvalid),
    .sram_axi_bready (sram_axi_bready),
    .sram_axi_araddr (sram_axi_araddr),
    .sram_axi_arvalid(sram_axi_arvalid),
    .sram_axi_arready(sram_axi_arready),
    .sram_axi_rdata  (sram_axi_rdata),
    .sram_axi_rresp  (sram_axi_rresp),
    .sram_axi_rvalid (sram_axi_rvalid),
    .sram_axi_rready (sram_axi_rready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] model_mem [int];
  logic [1:0]  exp_b_q [$];
  logic [33:0] exp_r_q [$];

  int   cyc    = 0;
  int   b_rise = 0;
  int   r_rise = 0;
  logic b_prev = 1'b0;
  logic r_prev = 1'b0;
  logic [1:0]  mon_eb;
  logic [33:0] mon_er;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int          idx;
    logic [31:0] w;
    if (a[31:14] != 0) begin
      exp_b_q.push_back(2'b10);
    end else begin
      idx = int'(a[13:2]);
      w   = model_mem.exists(idx) ? model_mem[idx] : 32'h0;
      for (int i = 0; i < 4; i++) if (s[i]) w[i*8 +: 8] = d[i*8 +: 8];
      model_mem[idx] = w;
      exp_b_q.push_back(2'b00);
    end
  endtask

  task automatic expect_read(input logic [31:0] a);
    int idx;
    if (a[31:14] != 0) begin
      exp_r_q.push_back({2'b10, 32'h0});
    end else begin
      idx = int'(a[13:2]);
      exp_r_q.push_back({2'b00, model_mem[idx]});
    end
  endtask

  // Handshake helpers: called and return one time unit after a rising edge.
  task automatic send_aw(input logic [31:0] a);
    logic ok = 1'b0;
    sram_axi_awaddr  = a;
    sram_axi_awvalid = 1'b1;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk) ok = sram_axi_awready;
      @(posedge clk) #1;
    end
    sram_axi_awvalid = 1'b0;
    check("aw_handshake", ok, 1'b1);
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    logic ok = 1'b0;
    sram_axi_wdata  = d;
    sram_axi_wstrb  = s;
    sram_axi_wvalid = 1'b1;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk) ok = sram_axi_wready;
      @(posedge clk) #1;
    end
    sram_axi_wvalid = 1'b0;
    check("w_handshake", ok, 1'b1);
  endtask

  task automatic send_ar(input logic [31:0] a);
    logic ok = 1'b0;
    sram_axi_araddr  = a;
    sram_axi_arvalid = 1'b1;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk) ok = sram_axi_arready;
      @(posedge clk) #1;
    end
    sram_axi_arvalid = 1'b0;
    check("ar_handshake", ok, 1'b1);
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    expect_write(a, d, s);
    fork
      send_aw(a);
      send_w(d, s);
    join
  endtask

  task automatic axi_read(input logic [31:0] a);
    expect_read(a);
    send_ar(a);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_b_q.size() != 0 || exp_r_q.size() != 0) && n < 100) begin
      @(posedge clk) #1;
      n++;
    end
    check("drain", n < 100, 1'b1);
    @(posedge clk) #1;
  endtask

  // Write and read accepted together; w_first says which must respond first.
  task automatic tie(input logic [31:0] wa, input logic [31:0] d, input logic [31:0] ra,
                     input logic w_first, input string tag);
    expect_write(wa, d, 4'hF);
    expect_read(ra);
    fork
      send_aw(wa);
      send_w(d, 4'hF);
      send_ar(ra);
    join
    drain();
    if (w_first) check(tag, 64'(r_rise - b_rise), 64'd1);
    else         check(tag, 64'(b_rise - r_rise), 64'd1);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (sram_axi_bvalid && !b_prev) b_rise = cyc;
      if (sram_axi_rvalid && !r_prev) r_rise = cyc;
      if (sram_axi_bvalid && sram_axi_bready) begin
        check("b_expected", exp_b_q.size() != 0, 1'b1);
        if (exp_b_q.size() != 0) begin
          mon_eb = exp_b_q.pop_front();
          check("bresp", sram_axi_bresp, mon_eb);
        end
      end
      if (sram_axi_rvalid && sram_axi_rready) begin
        check("r_expected", exp_r_q.size() != 0, 1'b1);
        if (exp_r_q.size() != 0) begin
          mon_er = exp_r_q.pop_front();
          check("rresp", sram_axi_rresp, mon_er[33:32]);
          check("rdata", sram_axi_rdata, mon_er[31:0]);
        end
      end
    end
    b_prev = sram_axi_bvalid;
    r_prev = sram_axi_rvalid;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_readys", {sram_axi_awready, sram_axi_wready, sram_axi_arready}, 3'b000);
    check("rst_bvalid", sram_axi_bvalid, 1'b0);
    check("rst_rvalid", sram_axi_rvalid, 1'b0);
    check("rst_bresp",  sram_axi_bresp, 2'b00);
    check("rst_rresp",  sram_axi_rresp, 2'b00);
    check("rst_rdata",  sram_axi_rdata, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_readys", {sram_axi_awready, sram_axi_wready, sram_axi_arready}, 3'b111);
    @(posedge clk) #1;

    // Basic write then read with latency checks.
    axi_write(32'h10, 32'hDEADBEEF, 4'hF);
    check("aw_busy", sram_axi_awready, 1'b0);
    check("b_lat1", sram_axi_bvalid, 1'b0);
    @(posedge clk) #1;
    check("b_lat2", sram_axi_bvalid, 1'b1);
    drain();
    axi_read(32'h10);
    check("r_lat1", sram_axi_rvalid, 1'b0);
    @(posedge clk) #1;
    check("r_lat2", sram_axi_rvalid, 1'b1);
    drain();

    // AW ahead of W, partial strobes over a full word.
    axi_write(32'h20, 32'hFFFFFFFF, 4'hF);
    drain();
    expect_write(32'h20, 32'h11223344, 4'b0101);
    fork
      begin
        send_aw(32'h20);
        check("aw_held", sram_axi_awready, 1'b0);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        send_w(32'h11223344, 4'b0101);
      end
    join
    drain();
    axi_read(32'h20);
    drain();

    // Out-of-range write and read; word 0 must survive the aliasing index.
    axi_write(32'h0, 32'h0BADF00D, 4'hF);
    drain();
    axi_write(32'h4000, 32'h12345678, 4'hF);
    drain();
    axi_read(32'h4000);
    drain();
    axi_read(32'h0);
    drain();

    // Arbitration ties alternate: W (last was R), R (last was W), W.
    tie(32'h40, 32'h01010101, 32'h10, 1'b1, "tie1_w_first");
    axi_write(32'h44, 32'h02020202, 4'hF);
    drain();
    tie(32'h48, 32'h03030303, 32'h20, 1'b0, "tie2_r_first");
    axi_read(32'h0);
    drain();
    tie(32'h4C, 32'h04040404, 32'h40, 1'b1, "tie3_w_first");
    axi_read(32'h4C);
    drain();

    // Read backpressure with a second AR queued.
    sram_axi_rready = 1'b0;
    axi_read(32'h10);
    axi_read(32'h20);
    check("ar_full", sram_axi_arready, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("r_stall_valid", sram_axi_rvalid, 1'b1);
      check("r_stall_data", sram_axi_rdata, 32'hDEADBEEF);
      check("r_stall_ar", sram_axi_arready, 1'b0);
    end
    @(posedge clk) #1;
    sram_axi_rready = 1'b1;
    @(posedge clk) #1;
    check("r_no_bubble", sram_axi_rvalid, 1'b1);
    check("r_second_data", sram_axi_rdata, 32'hFF22FF44);
    drain();

    // Reset while AW is held and W never arrives.
    axi_write(32'h30, 32'hA5A5A5A5, 4'hF);
    drain();
    send_aw(32'h30);
    rst = 1'b1;
    @(posedge clk) #1;
    check("mid_rst_readys", {sram_axi_awready, sram_axi_wready, sram_axi_arready}, 3'b000);
    check("mid_rst_bvalid", sram_axi_bvalid, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_ready_back", {sram_axi_awready, sram_axi_wready, sram_axi_arready}, 3'b111);
    check("mid_rst_no_b", sram_axi_bvalid, 1'b0);
    @(posedge clk) #1;
    axi_read(32'h30);
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
